// File: rtl/cart_bank_ctrl.sv
// Cartridge bank-switching controller and ROM-port arbiter.
// Decodes F8/F6/F4 hotspot accesses to select a 4 KB bank, forms the ROM
// address, and hands the ROM write port to the host loader while holding the
// CPU stalled at a bus-cycle boundary.
//
// Handshake: the loader raises load_req_i (level) and must keep it high for as
// long as it wants the port; it may only write (load_wr_i) while load_ack_o is
// high, at most one byte per clock; dropping load_req_i returns the port to the
// CPU after a single RELEASE clock. stall_cpu_o is high in every state except
// IDLE.
module cart_bank_ctrl #(
  parameter int ROM_ADDR_BITS = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [12:0]              cpu_adr_i,
  input  logic [1:0]               mode_i,
  input  logic                     load_req_i,
  input  logic                     load_wr_i,
  input  logic [ROM_ADDR_BITS-1:0] load_adr_i,
  input  logic [7:0]               load_dat_i,
  output logic                     load_ack_o,
  output logic                     stall_cpu_o,
  output logic [ROM_ADDR_BITS-1:0] rom_adr_o,
  output logic [7:0]               rom_dat_o,
  output logic                     rom_we_o,
  output logic [2:0]               bank_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_F8   = 2'd1;
  localparam logic [1:0] MODE_F6   = 2'd2;
  localparam logic [1:0] MODE_F4   = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  bank_q, bank_d;
  logic [11:0] adr_lo;
  logic [11:0] f6_off;
  logic [11:0] f4_off;
  logic [2:0]  bank_masked;

  // The bank a freshly selected image starts in: the last one.
  function automatic logic [2:0] power_up_bank(input logic [1:0] mode);
    case (mode)
      MODE_F8: power_up_bank = 3'd1;
      MODE_F6: power_up_bank = 3'd3;
      MODE_F4: power_up_bank = 3'd7;
      default: power_up_bank = 3'd0;
    endcase
  endfunction

  assign adr_lo = cpu_adr_i[11:0];
  assign f6_off = adr_lo - 12'hFF6;
  assign f4_off = adr_lo - 12'hFF4;

  // State, mode and bank registers; reset reloads mode and its power-up bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= mode_i;
      bank_q  <= power_up_bank(mode_i);
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bank_q  <= bank_d;
    end
  end

  // Next-state logic for the port arbiter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_req_i) state_d = DRAIN;
      DRAIN: begin
        // A dropped request wins over a coincident bus-cycle strobe.
        if (!load_req_i)   state_d = IDLE;
        else if (enable_i) state_d = LOAD;
      end
      LOAD:    if (!load_req_i) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hotspot decode (CPU-owned bus cycles only) and post-load mode/bank reload.
  always_comb begin
    bank_d = bank_q;
    mode_d = mode_q;
    if (state_q == RELEASE) begin
      mode_d = mode_i;
      bank_d = power_up_bank(mode_i);
    end else if (state_q == IDLE && enable_i && cpu_adr_i[12]) begin
      case (mode_q)
        MODE_F8: begin
          if (adr_lo == 12'hFF8) bank_d = 3'd0;
          if (adr_lo == 12'hFF9) bank_d = 3'd1;
        end
        MODE_F6: begin
          if (adr_lo >= 12'hFF6 && adr_lo <= 12'hFF9) bank_d = {1'b0, f6_off[1:0]};
        end
        MODE_F4: begin
          if (adr_lo >= 12'hFF4 && adr_lo <= 12'hFFB) bank_d = f4_off[2:0];
        end
        default: bank_d = bank_q;
      endcase
    end
  end

  // Only as many bank bits as the mapper uses reach the ROM address.
  always_comb begin
    bank_masked = 3'd0;
    case (mode_q)
      MODE_F8:   bank_masked = {2'b00, bank_q[0]};
      MODE_F6:   bank_masked = {1'b0, bank_q[1:0]};
      MODE_F4:   bank_masked = bank_q;
      MODE_NONE: bank_masked = 3'd0;
      default:   bank_masked = 3'd0;
    endcase
  end

  // ROM port mux: loader address while it owns the port, CPU address otherwise.
  always_comb begin
    rom_adr_o = ROM_ADDR_BITS'({bank_masked, adr_lo});
    if (state_q == LOAD) rom_adr_o = load_adr_i;
  end

  assign rom_dat_o   = load_dat_i;
  assign rom_we_o    = load_wr_i & (state_q == LOAD);
  assign stall_cpu_o = (state_q != IDLE);
  assign load_ack_o  = (state_q == LOAD);
  assign bank_o      = bank_q;
  assign state_o     = state_q;

endmodule

// File: doc/cart_bank_ctrl.md
# cart_bank_ctrl

Cartridge bank-switching controller and ROM-port arbiter for the Atari 2600 core. It sits between the 6502 bus and the cartridge ROM. It decodes the standard F8/F6/F4 hotspot accesses to select a 4 KB bank, and forms the ROM address. It also grants the ROM write port to the SPI host loader, stalling the CPU at a bus-cycle boundary while a new image is written.

## Interface
Parameters:
- `ROM_ADDR_BITS`, 15, ROM address width (32 KB max image).

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  CPU-domain clock (18.9 MHz domain)
- `rst_i`  in  1  synchronous active-high reset
- `enable_i`  in  1  one-clock strobe marking a CPU bus cycle (the `cpu_enable` strobe)
- `cpu_adr_i`  in  13  CPU address A12..A0
- `mode_i`  in  2  mapper select: 0 none (2K/4K), 1 F8 (8K), 2 F6 (16K), 3 F4 (32K)
- `load_req_i`  in  1  host loader requests the ROM port (level)
- `load_wr_i`  in  1  loader write strobe, honoured only while `load_ack_o`
- `load_adr_i`  in  15  loader byte address
- `load_dat_i`  in  8  loader write data
- `load_ack_o`  out  1  loader owns the ROM port
- `stall_cpu_o`  out  1  to CPU RDY logic (ORed with TIA stall)
- `rom_adr_o`  out  15  ROM address
- `rom_dat_o`  out  8  ROM write data
- `rom_we_o`  out  1  ROM write enable
- `bank_o`  out  3  current bank, for diagnostics

## Operation
- Latched mode register `mode_q`. It captures `mode_i` during `rst_i` and in RELEASE. Hotspots and masking use `mode_q` only.
- Power-up bank is the last bank: F8 → 1, F6 → 3, F4 → 7, none → 0. It is applied on reset and in RELEASE.
- Hotspots are decoded only in IDLE with `enable_i`=1 and A12=1. Reads and writes both trigger.
  - F8: $1FF8→0, $1FF9→1.
  - F6: $1FF6..$1FF9→0..3.
  - F4: $1FF4..$1FFB→4'h(adr−$1FF4) = 0..7.
  - Mode none: no hotspots.
  - Any other address leaves the bank unchanged.
- `rom_adr_o` is combinational:
  - LOAD: `load_adr_i`.
  - Otherwise: {bank masked to mode width, `cpu_adr_i[11:0]`}. Upper bits are zero (none: all bank bits 0; F8: 1 bit; F6: 2; F4: 3).
- `rom_dat_o` = `load_dat_i`. `rom_we_o` = `load_wr_i` & LOAD. It is never asserted in any other state.
- FSM states:
  - IDLE: CPU owns the port; `stall_cpu_o`=0. `load_req_i` → DRAIN.
  - DRAIN: `stall_cpu_o`=1; hotspots ignored. If `load_req_i` drops, go to IDLE with the bank unchanged. Else, on a clock with `enable_i`=1, go to LOAD next clock.
  - LOAD: `stall_cpu_o`=1, `load_ack_o`=1. `load_req_i`=0 → RELEASE.
  - RELEASE: one clock. `stall_cpu_o`=1, `load_ack_o`=0. Latch `mode_q`, set the power-up bank, then go to IDLE.

## Timing
- Reset values: state IDLE, `load_ack_o`=0, `stall_cpu_o`=0, `rom_we_o`=0. `bank_o` = power-up bank of `mode_i` sampled during reset.
- Bank update is registered. A hotspot on the `enable_i` clock at cycle N changes `bank_o` and `rom_adr_o` at N+1.
- `stall_cpu_o` and `load_ack_o` are registered state decodes. `stall_cpu_o` rises 1 clock after `load_req_i` is sampled high in IDLE.
- `load_ack_o` rises 1 clock after the first `enable_i` seen in DRAIN. If `enable_i` coincides with the DRAIN entry clock, that counts.
- Hotspot and `load_req_i` on the same IDLE clock: the bank changes AND the state goes to DRAIN.
- `rst_i` at any time, including mid-LOAD, forces the reset values on the next clock. A write in flight on that clock is still issued (combinational); none follow.
- Loader writes take effect in ROM on the clock `rom_we_o` is high. Any write rate is permitted, one per clock max.

## Test plan
- Reset with `mode_i`=2 (F6) → `bank_o`=3, `stall_cpu_o`=0. Access $1FF7 with `enable_i` → `bank_o`=1 next clock. Read $1234 → `rom_adr_o`=15'h1234.
- F8: access $1FF8 → bank 0, `rom_adr_o` for $1ABC = 15'h0ABC. Access $1FF9 → 15'h1ABC. Access $0FF9 (A12=0) → no change. Access $1FF9 without `enable_i` → no change.
- F4: sweep $1FF4..$1FFB → banks 0..7. $1FF3 and $1FFC leave the bank unchanged. Mode none: $1FF8 → `bank_o` stays 0.
- Load handshake: assert `load_req_i` in IDLE → `stall_cpu_o`=1 next clock. With `enable_i` held low 5 clocks, `load_ack_o` stays 0. Pulse `enable_i` → `load_ack_o`=1 next clock. Write 8'hA5 to 15'h7FFC → `rom_we_o`=1, `rom_adr_o`=15'h7FFC. Drop the request → one RELEASE clock, then IDLE, bank = power-up bank of the new `mode_i`.
- Abort and reset: drop `load_req_i` in DRAIN → IDLE, bank preserved, no `rom_we_o`. Assert `rst_i` mid-LOAD → next clock `load_ack_o`=0, `stall_cpu_o`=0, IDLE.
- Simultaneous: hotspot $1FF8 (F8, bank 1) and `load_req_i` rise on the same `enable_i` clock → `bank_o`=0 and `stall_cpu_o`=1 on the next clock.
